// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if
//   Byte handshake between the command bridge and the UART wrapper.
//   master : the bridge (consumes received bytes, requests transmits)
//   slave  : the UART side (delivers received bytes, runs the transmitter)
// Signals
//   rx_data [7:0]  received byte, valid while rx_done is high
//   rx_done        one-cycle pulse, new byte on rx_data
//   tx_data [7:0]  byte to transmit, stable from tx_en until tx_done
//   tx_en          one-cycle transmit request
//   tx_busy        transmitter busy
//   tx_done        one-cycle pulse, transmitted frame complete
interface uart_reg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  rx_data,
        input  rx_done,
        input  tx_busy,
        input  tx_done,
        output tx_data,
        output tx_en
    );

    modport slave (
        output rx_data,
        output rx_done,
        output tx_busy,
        output tx_done,
        input  tx_data,
        input  tx_en
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Command responder sitting between the UART receiver and transmitter.
//   Decodes one-byte read/write commands from the receive stream, owns a bank
//   of NREGS 8-bit registers and answers every accepted command with exactly
//   one byte: ACK (0x06) after a write, the register value after a read, or
//   NAK (0x15) on a malformed command, bad address or data-byte timeout.
//
//   Command byte: bit7 = 1 write / 0 read, bits6:4 must be 000, bits3:0 address.
//
// Parameters
//   NREGS    number of registers (1..16), address is always 4 bits
//   TIMEOUT  max clk cycles allowed between a write command and its data byte
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        uart_reg_bridge_if.master (rx byte stream in, tx request out)
//   regs_out   register bank, reg i at bits [8i+7:8i]
//   wr_strobe  one-cycle pulse on every register write
//   wr_addr    address of the last write
//   err_count  saturating count of NAK and overrun events
//
// Build option
//   UART_REG_BRIDGE_TIMEOUT_EN  when defined, a write command whose data byte
//   does not arrive within TIMEOUT cycles is answered with NAK. When not
//   defined the bridge waits for the data byte indefinitely and TIMEOUT has
//   no effect.
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a command byte
//   GET_DATA | write accepted, waiting for its data byte
//   SEND     | response ready, waiting for the transmitter to be free
//   WAIT_TX  | response handed to the transmitter, waiting for tx_done
module uart_reg_bridge #(
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_reg_bridge_if.master     bus,
    output logic [NREGS*8-1:0]    regs_out,
    output logic                  wr_strobe,
    output logic [3:0]            wr_addr,
    output logic [7:0]            err_count
);

    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;
    localparam logic [4:0] NREGS5 = 5'(NREGS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        SEND     = 2'd2,
        WAIT_TX  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] regs [NREGS];
    logic [3:0] addr_q;
    logic [7:0] resp;
    logic [7:0] rd_byte;
    logic       cmd_ok;

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    // Down-counter loaded on entry to GET_DATA; zero is the last cycle the
    // data byte is still accepted, so the NAK goes out TIMEOUT+1 cycles
    // after entering GET_DATA.
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
    logic [TW-1:0] timer;
`else
    // TIMEOUT has no effect in this build.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reserved bits clear and address inside the bank.
    assign cmd_ok = (bus.rx_data[6:4] == 3'b000) &&
                    ({1'b0, bus.rx_data[3:0]} < NREGS5);

    // Explicit mux keeps out-of-range addresses from indexing past the bank.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rx_data[3:0] == 4'(i)) begin
                rd_byte = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.tx_en   <= 1'b0;
            bus.tx_data <= 8'h00;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
            wr_strobe   <= 1'b0;
            wr_addr     <= 4'h0;
            err_count   <= 8'h00;
            addr_q      <= 4'h0;
            resp        <= 8'h00;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            bus.tx_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rx_done) begin
                        if (!cmd_ok) begin
                            resp      <= NAK;
                            err_count <= sat_inc(err_count);
                            state     <= SEND;
                        end else if (bus.rx_data[7]) begin
                            addr_q <= bus.rx_data[3:0];
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
                            timer  <= TIMER_LOAD;
`endif
                            state  <= GET_DATA;
                        end else begin
                            resp  <= rd_byte;
                            state <= SEND;
                        end
                    end
                end

                GET_DATA: begin
                    // A byte arriving on the expiry cycle still completes the write.
                    if (bus.rx_done) begin
                        for (int i = 0; i < NREGS; i++) begin
                            if (addr_q == 4'(i)) begin
                                regs[i] <= bus.rx_data;
                            end
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= addr_q;
                        resp      <= ACK;
                        state     <= SEND;
                    end
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
                    else if (timer == '0) begin
                        resp      <= NAK;
                        err_count <= sat_inc(err_count);
                        state     <= SEND;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end

                SEND: begin
                    // Bytes arriving while a response is pending are dropped.
                    if (bus.rx_done) begin
                        err_count <= sat_inc(err_count);
                    end
                    if (!bus.tx_busy) begin
                        bus.tx_data <= resp;
                        bus.tx_en   <= 1'b1;
                        state       <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (bus.rx_done) begin
                        err_count <= sat_inc(err_count);
                    end
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;
    localparam int NR    = 8;
    localparam int TO    = 100;
    localparam int TXLEN = 8;

    localparam int EV_WR   = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_RESP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_reg_bridge_if bus();

    logic [NR*8-1:0] regs_out;
    logic            wr_strobe;
    logic [3:0]      wr_addr;
    logic [7:0]      err_count;

    logic tx_busy_m = 1'b0;
    logic hold_busy = 1'b0;
    logic in_flight = 1'b0;
    assign bus.tx_busy = tx_busy_m | hold_busy;

    uart_reg_bridge #(.NREGS(NR), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_count (err_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Expected effects, each stamped with the cycle it must become visible.
    typedef struct {
        int         c;
        int         k;
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;
    ev_t        evq[$];
    logic [7:0] mregs [NR];
    logic [7:0] merr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int c, input int k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.c = c; e.k = k; e.a = a; e.d = d;
        evq.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        merr = 8'h00;
        evq.delete();
    endtask

    // Compare process: applies due model events then checks every output.
    always @(negedge clk) begin
        logic            exp_wr;
        logic            exp_tx;
        logic [3:0]      exp_wa;
        logic [7:0]      exp_td;
        logic [NR*8-1:0] expv;
        exp_wr = 1'b0; exp_tx = 1'b0; exp_wa = 4'h0; exp_td = 8'h00;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].c < cyc) begin
                chk("event_missed", 64'(cyc), 64'(evq[i].c));
                evq.delete(i);
            end else if (evq[i].c == cyc) begin
                case (evq[i].k)
                    EV_WR: begin
                        mregs[evq[i].a] = evq[i].d;
                        exp_wr = 1'b1;
                        exp_wa = evq[i].a;
                    end
                    EV_ERR: merr = (merr == 8'hFF) ? merr : merr + 8'd1;
                    default: begin
                        exp_tx = 1'b1;
                        exp_td = evq[i].d;
                    end
                endcase
                evq.delete(i);
            end
        end
        for (int i = 0; i < NR; i++) expv[8*i +: 8] = mregs[i];
        chk("regs_out", regs_out, expv);
        chk("err_count", err_count, merr);
        chk("wr_strobe", wr_strobe, exp_wr);
        if (exp_wr && wr_strobe) chk("wr_addr", wr_addr, exp_wa);
        chk("tx_en", bus.tx_en, exp_tx);
        if (exp_tx && bus.tx_en) chk("tx_data", bus.tx_data, exp_td);
    end

    // Transmitter model: busy for TXLEN cycles after each tx_en, then tx_done.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) begin
                in_flight = 1'b1;
                @(posedge clk); #1 tx_busy_m = 1'b1;
                repeat (TXLEN - 1) @(posedge clk);
                #1;
                bus.tx_done = 1'b1;
                tx_busy_m   = 1'b0;
                @(posedge clk); #1 bus.tx_done = 1'b0;
                in_flight = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int n);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((evq.size() != 0 || in_flight) && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        if (evq.size() != 0 || in_flight) begin
            n_total++;
            $display("FAIL wait_idle: response still pending after %0d cycles, required idle", bound);
            evq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Command with a plain NAK answer (decode error).
    task automatic bad_cmd(input logic [7:0] b);
        int n;
        send_byte(b, n);
        push_ev(n + 1, EV_ERR, 4'h0, 8'h00);
        push_ev(n + 2, EV_RESP, 4'h0, 8'h15);
        wait_idle(100);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        int n;
        int m;
        send_byte({4'h8, a}, n);
        send_byte(d, m);
        push_ev(m + 1, EV_WR, a, d);
        push_ev(m + 2, EV_RESP, 4'h0, 8'h06);
        wait_idle(100);
    endtask

    task automatic read_reg(input logic [3:0] a, input logic [7:0] d);
        int n;
        send_byte({4'h0, a}, n);
        push_ev(n + 2, EV_RESP, 4'h0, d);
        wait_idle(100);
    endtask

    initial begin
        int n;
        int n2;
        int m;
        int r;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        model_reset();

        #2 rst = 1'b0;
        #1;
        chk("reset_regs_out", regs_out, 64'h0);
        chk("reset_err_count", err_count, 8'h00);
        chk("reset_tx_en", bus.tx_en, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Write then read back.
        write_reg(4'h3, 8'h5A);
        chk("lit_reg3", regs_out[31:24], 8'h5A);
        chk("lit_err_after_write", err_count, 8'h00);
        read_reg(4'h3, 8'h5A);

        // Decode errors: reserved bits, address beyond bank, first bad address.
        bad_cmd(8'h40);
        chk("lit_err_reserved", err_count, 8'h01);
        bad_cmd(8'h0A);
        chk("lit_err_addr_a", err_count, 8'h02);
        bad_cmd(8'h08);
        chk("lit_err_addr_8", err_count, 8'h03);

        // Highest valid address.
        write_reg(4'h7, 8'hA5);
        chk("lit_reg7", regs_out[63:56], 8'hA5);
        read_reg(4'h7, 8'hA5);
        read_reg(4'h0, 8'h00);

        // Backpressure, with a stray byte while the response is held in SEND.
        hold_busy = 1'b1;
        send_byte(8'h03, n);
        repeat (20) @(posedge clk);
        send_byte(8'h99, n2);
        push_ev(n2 + 1, EV_ERR, 4'h0, 8'h00);
        repeat (30) @(posedge clk);
        #1;
        hold_busy = 1'b0;
        r = cyc;
        push_ev(r + 1, EV_RESP, 4'h0, 8'h5A);
        wait_idle(100);
        chk("lit_err_overrun_send", err_count, 8'h04);

        // Overrun while the response frame is in the transmitter.
        send_byte(8'h03, n);
        push_ev(n + 2, EV_RESP, 4'h0, 8'h5A);
        repeat (2) @(posedge clk);
        send_byte(8'hEE, n2);
        push_ev(n2 + 1, EV_ERR, 4'h0, 8'h00);
        wait_idle(100);
        chk("lit_err_overrun_wait", err_count, 8'h05);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
        // Data byte never arrives: NAK TIMEOUT+1 cycles after entering GET_DATA.
        send_byte(8'h81, n);
        push_ev(n + 1 + TO, EV_ERR, 4'h0, 8'h00);
        push_ev(n + 2 + TO, EV_RESP, 4'h0, 8'h15);
        wait_idle(300);
        chk("lit_err_timeout", err_count, 8'h06);

        // Data byte lands on the expiry cycle: write wins, no error.
        send_byte(8'h82, n);
        while (cyc < n + TO - 1) begin
            @(posedge clk); #1;
        end
        send_byte(8'hC3, m);
        push_ev(m + 1, EV_WR, 4'h2, 8'hC3);
        push_ev(m + 2, EV_RESP, 4'h0, 8'h06);
        wait_idle(100);
        chk("lit_reg2_edge", regs_out[23:16], 8'hC3);
        chk("lit_err_edge", err_count, 8'h06);
`else
        // No timeout: GET_DATA waits as long as needed.
        send_byte(8'h81, n);
        repeat (10000) @(posedge clk);
        send_byte(8'h22, m);
        push_ev(m + 1, EV_WR, 4'h1, 8'h22);
        push_ev(m + 2, EV_RESP, 4'h0, 8'h06);
        wait_idle(100);
        chk("lit_reg1_late", regs_out[15:8], 8'h22);
        chk("lit_err_no_timeout", err_count, 8'h05);
`endif

        // Asynchronous reset in the middle of a write.
        send_byte(8'h85, n);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_regs_out", regs_out, 64'h0);
        chk("midrst_err_count", err_count, 8'h00);
        chk("midrst_wr_strobe", wr_strobe, 1'b0);
        chk("midrst_wr_addr", wr_addr, 4'h0);
        chk("midrst_tx_en", bus.tx_en, 1'b0);
        chk("midrst_tx_data", bus.tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        read_reg(4'h5, 8'h00);

        // Saturation: every bad command still answered, counter stops at 0xFF.
        for (int i = 0; i < 300; i++) bad_cmd(8'h70);
        chk("lit_err_saturated", err_count, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

- Byte-level command responder between the UART receiver and transmitter: decodes host commands from the receive byte stream and answers each one over the transmit path.
- Owns a small bank of 8-bit read/write registers, driven out to the rest of the FPGA design (LED/HEX drivers, test knobs).
- Sits above the UART wrapper in the top-level:
  - replaces the RX→TX loopback;
  - consumes the receiver's data/done pulse;
  - drives the transmitter's data/enable, observing its busy/done.

## Interface
- NREGS, 16, number of registers, 1..16; address width fixed at 4 bits
- TIMEOUT, 500000, max clk cycles between command byte and data byte of a write
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte, valid when rx_done=1
- rx_done  input  1  one-cycle pulse, new byte on rx_data
- tx_data  output  8  byte to transmit, held stable from tx_en until tx_done
- tx_en  output  1  one-cycle transmit request
- tx_busy  input  1  transmitter busy
- tx_done  input  1  one-cycle pulse, transmitted frame complete
- regs_out  output  NREGS*8  register bank, reg i at bits [8i+7:8i]
- wr_strobe  output  1  one-cycle pulse on every register write
- wr_addr  output  4  address of last write, valid with wr_strobe
- err_count  output  8  saturating count of NAK events

## Operation
- Command byte format:
  - bit7: 1=write, 0=read;
  - bits6:4: must be 000;
  - bits3:0: address.
- Responses: ACK=0x06 (write done); read data byte (read); NAK=0x15 (error).
- States: IDLE, GET_DATA, SEND, WAIT_TX.
- IDLE, on rx_done, decode rx_data:
  - bits6:4≠0 or addr≥NREGS → resp=NAK, err_count+1, →SEND;
  - write → latch addr, clear timer, →GET_DATA;
  - read → resp=regs[addr], →SEND.
- GET_DATA:
  - on rx_done → regs[addr]=rx_data, wr_strobe=1, wr_addr=addr, resp=ACK, →SEND;
  - otherwise timer+1; timer reaches TIMEOUT-1 → resp=NAK, err_count+1, →SEND.
- SEND: when tx_busy=0 → tx_data=resp, tx_en=1 for one cycle, →WAIT_TX. While tx_busy=1, hold in SEND with tx_en=0.
- WAIT_TX: on tx_done → IDLE.
- Bytes arriving in SEND or WAIT_TX:
  - discarded, no response;
  - err_count+1 (overrun);
  - state unaffected.
- err_count saturates at 0xFF; never wraps.
- Simultaneous rx_done and timeout expiry in GET_DATA: the byte wins; write completes with ACK, no error counted.
- Reset values (async, immediate, including mid-transaction):
  - state=IDLE;
  - tx_en=0, tx_data=0x00;
  - regs_out all 0, wr_strobe=0, wr_addr=0, err_count=0, timer=0.
- Reset does not abort a frame already inside the transmitter.

## Timing
- All outputs registered.
- Read: rx_done at cycle N → SEND at N+1 → tx_en=1 at N+2 (tx_busy low), tx_data=reg value at N+2.
- Write data byte: rx_done at cycle M → regs_out and wr_strobe updated at M+1 → tx_en at M+2.
- NAK on decode error: tx_en at N+2.
- NAK on timeout: tx_en exactly TIMEOUT+1 cycles after entering GET_DATA.
- regs_out reflects a write no later than the cycle wr_strobe is high.
- tx_en is never high in two consecutive cycles; at most one tx_en per command.
- Every accepted command produces exactly one response byte, except with timeout compiled out (see Configuration).

## Configuration
- UART_REG_BRIDGE_TIMEOUT_EN defined:
  - GET_DATA timer active;
  - expiry answers NAK and counts an error, as above.
- Not defined:
  - timer and TIMEOUT logic omitted;
  - GET_DATA waits indefinitely for the data byte;
  - the TIMEOUT parameter is ignored.

## Test plan
- Write, then read back:
  - rx 0x83 then 0x5A → wr_strobe one cycle with wr_addr=3; regs_out[31:24]=0x5A; tx_data=0x06 with tx_en; err_count=0.
  - then rx 0x03 → tx_data=0x5A, tx_en two cycles after rx_done.
- Invalid command and bad address:
  - rx 0x40 → tx_data=0x15, err_count=1.
  - NREGS=8, rx 0x0A → 0x15, err_count=2.
- Timeout (macro defined, TIMEOUT=100): rx 0x81, no further bytes → NAK tx_en 101 cycles after GET_DATA entry, regs unchanged, err_count=1. Macro undefined: no response after 10000 cycles; then rx 0x22 → regs[1]=0x22, ACK.
- Backpressure and overrun:
  - tx_busy held high 50 cycles after a read command → tx_en withheld, asserted the cycle after tx_busy falls;
  - rx_done during WAIT_TX → ignored, err_count+1.
- Reset mid-write: rx 0x85, assert rst in GET_DATA → all outputs at reset values asynchronously; after release, rx 0x05 reads 0x00.
- Saturation: 300 invalid commands → err_count=0xFF, each still answered with 0x15.
